// File: rtl/stim_pkg.sv
// Shared constants for the filter stimulus source: mode codes, FSM encoding, PRBS-9 taps.
package stim_pkg;

    localparam logic [1:0] MODE_IMPULSE = 2'd0;
    localparam logic [1:0] MODE_STEP    = 2'd1;
    localparam logic [1:0] MODE_ASK     = 2'd2;
    localparam logic [1:0] MODE_SQUARE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // x^9 + x^5 + 1, output taken from the MSB
    localparam int unsigned PRBS_LEN   = 9;
    localparam int unsigned PRBS_TAP_A = 8;
    localparam int unsigned PRBS_TAP_B = 4;

    localparam logic [PRBS_LEN-1:0] DEFAULT_SEED = 9'h1FF;

endpackage

// File: rtl/prbs9_lfsr.sv
// Fibonacci PRBS-9 generator presenting two bits (b1 first) per symbol.
module prbs9_lfsr
    import stim_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = DEFAULT_SEED
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       load,
    input  logic       adv,
    output logic [1:0] o_sym
);

    logic [PRBS_LEN-1:0] r_lfsr;
    logic [PRBS_LEN-1:0] w_step1;
    logic [PRBS_LEN-1:0] w_step2;

    // Two single-bit shifts per advance so the next symbol sits in the top two bits
    always_comb begin
        w_step1 = {r_lfsr[PRBS_LEN-2:0], r_lfsr[PRBS_TAP_A] ^ r_lfsr[PRBS_TAP_B]};
        w_step2 = {w_step1[PRBS_LEN-2:0], w_step1[PRBS_TAP_A] ^ w_step1[PRBS_TAP_B]};
    end

    always_ff @(posedge sys_clk) begin
        if (reset || load) begin
            r_lfsr <= SEED;
        end else if (adv) begin
            r_lfsr <= w_step2;
        end
    end

    assign o_sym = {r_lfsr[PRBS_LEN-1], r_lfsr[PRBS_LEN-2]};

endmodule

// File: rtl/stim_source.sv
// Strobe-paced stimulus generator: impulse, step, 4-ASK PRBS and square bursts.
module stim_source
    import stim_pkg::*;
#(
    parameter int unsigned         WIDTH = 18,
    parameter int unsigned         LEN_W = 16,
    parameter int unsigned         SPS   = 4,
    parameter logic [PRBS_LEN-1:0] SEED  = DEFAULT_SEED
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] amp,
    input  logic [LEN_W-1:0]        length,
    output logic signed [WIDTH-1:0] x_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W = $clog2(SPS) + 1;
    localparam logic [CNT_W-1:0] SPS_LAST = CNT_W'(SPS - 1);
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic signed [WIDTH-1:0] r_amp;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_n;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_half;

    logic [1:0]              w_sym;
    logic                    w_load;
    logic                    w_adv;
    logic                    w_last;
    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_a3;
    logic signed [WIDTH-1:0] w_ask;
    logic signed [WIDTH-1:0] w_sq_hi;
    logic signed [WIDTH-1:0] w_sq_lo;
    logic signed [WIDTH-1:0] w_sample;

    assign w_load = (r_state == ST_IDLE) && start;
    // Step the PRBS after the last sample of each symbol so o_sym holds for the whole symbol
    assign w_adv  = (r_state == ST_RUN) && sam_clk_en && (r_mode == MODE_ASK)
                    && (r_len != '0) && (r_cnt == SPS_LAST);
    assign w_last = (r_n == (r_len - LEN_W'(1)));

    prbs9_lfsr #(
        .SEED (SEED)
    ) u_prbs (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (w_load),
        .adv     (w_adv),
        .o_sym   (w_sym)
    );

    // Level mapper: 4-ASK levels and a square wave of magnitude |amp| starting positive
    always_comb begin
        w_a     = r_amp >>> 2;
        w_a3    = w_a + (w_a <<< 1);
        w_ask   = -w_a3;
        w_sq_hi = r_amp;
        w_sq_lo = -r_amp;
        w_sample = '0;
        case (w_sym)
            2'b11:   w_ask = w_a3;
            2'b10:   w_ask = w_a;
            2'b01:   w_ask = -w_a;
            default: w_ask = -w_a3;
        endcase
        if (r_amp[WIDTH-1]) begin
            w_sq_hi = (r_amp == MIN_NEG) ? MAX_POS : -r_amp;
            w_sq_lo = r_amp;
        end
        case (r_mode)
            MODE_IMPULSE: w_sample = (r_n == '0) ? r_amp : '0;
            MODE_STEP:    w_sample = r_amp;
            MODE_ASK:     w_sample = w_ask;
            default:      w_sample = r_half ? w_sq_lo : w_sq_hi;
        endcase
    end

    // Burst FSM with registered sample and handshake outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_IMPULSE;
            r_amp   <= '0;
            r_len   <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_half  <= 1'b0;
            x_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    x_out <= '0;
                    if (start) begin
                        r_mode  <= mode;
                        r_amp   <= amp;
                        r_len   <= length;
                        r_n     <= '0;
                        r_cnt   <= '0;
                        r_half  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sam_clk_en) begin
                        if (r_len == '0) begin
                            // Empty burst: finish on the first strobe without a sample
                            x_out   <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            x_out <= w_sample;
                            r_n   <= r_n + LEN_W'(1);
                            if (r_cnt == SPS_LAST) begin
                                r_cnt  <= '0;
                                r_half <= ~r_half;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                            if (w_last) begin
                                r_state <= ST_TAIL;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (sam_clk_en) begin
                        x_out   <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_source.sv
// Scoreboard bench for stim_source: two instances (SPS=4 and SPS=2) share clock and strobe.
module tb_stim_source;

    localparam int W = 18;
    localparam int L = 16;

    typedef struct {
        logic signed [W-1:0] x;
        logic                d;
        logic                b;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sam_clk_en = 1'b0;
    logic                start_a = 1'b0;
    logic                start_b = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic signed [W-1:0] amp = '0;
    logic [L-1:0]        length = '0;
    logic signed [W-1:0] xa, xb;
    logic                busy_a, busy_b, done_a, done_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ev_a = 0;
    int   ev_b = 0;

    always #5 clk = ~clk;

    stim_source #(.WIDTH(W), .LEN_W(L), .SPS(4), .SEED(9'h1FF)) u_dut_a (
        .sys_clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .start(start_a),
        .mode(mode), .amp(amp), .length(length),
        .x_out(xa), .busy(busy_a), .done(done_a)
    );

    stim_source #(.WIDTH(W), .LEN_W(L), .SPS(2), .SEED(9'h1FF)) u_dut_b (
        .sys_clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .start(start_b),
        .mode(mode), .amp(amp), .length(length),
        .x_out(xb), .busy(busy_b), .done(done_b)
    );

    function automatic void push(input logic which, input int x, input logic d, input logic b);
        exp_t e;
        e.x = W'(x);
        e.d = d;
        e.b = b;
        if (which) qb.push_back(e);
        else       qa.push_back(e);
    endfunction

    // Independent 4-ASK model: one-bit-per-step PRBS-9 from the seed, SPS=4 instance
    function automatic void push_ask(input int a_in, input int len);
        logic [8:0] lf;
        logic       b1, b0;
        int         a, lvl;
        lf  = 9'h1FF;
        a   = a_in >>> 2;
        lvl = 0;
        for (int n = 0; n < len; n++) begin
            if (n % 4 == 0) begin
                b1 = lf[8];
                lf = {lf[7:0], lf[8] ^ lf[4]};
                b0 = lf[8];
                lf = {lf[7:0], lf[8] ^ lf[4]};
                case ({b1, b0})
                    2'b11:   lvl = 3 * a;
                    2'b10:   lvl = a;
                    2'b01:   lvl = -a;
                    default: lvl = -3 * a;
                endcase
            end
            push(1'b0, lvl, 1'b0, 1'b1);
        end
        push(1'b0, 0, 1'b1, 1'b0);
    endfunction

    function automatic void chk_item(input string nm, input int idx, input exp_t e,
                                     input logic signed [W-1:0] x, input logic d, input logic b);
        n_chk++;
        if (x !== e.x || d !== e.d || b !== e.b) begin
            n_fail++;
            $display("FAIL %s event %0d: got x_out=%0d done=%0b busy=%0b, want x_out=%0d done=%0b busy=%0b",
                     nm, idx, x, d, b, e.x, e.d, e.b);
        end
    endfunction

    function automatic void chk_sig(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endfunction

    // Monitor: a strobe seen while busy is an output event; pop and compare
    initial begin
        logic sa, sb;
        exp_t e;
        forever begin
            @(posedge clk);
            sa = sam_clk_en & busy_a;
            sb = sam_clk_en & busy_b;
            #1;
            if (sa) begin
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL dut_a unexpected output: x_out=%0d done=%0b", xa, done_a);
                end else begin
                    e = qa.pop_front();
                    chk_item("dut_a", ev_a, e, xa, done_a, busy_a);
                end
                ev_a++;
            end else if (done_a) begin
                n_fail++;
                $display("FAIL dut_a spurious done: got done=1, want 0");
            end
            if (sb) begin
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL dut_b unexpected output: x_out=%0d done=%0b", xb, done_b);
                end else begin
                    e = qb.pop_front();
                    chk_item("dut_b", ev_b, e, xb, done_b, busy_b);
                end
                ev_b++;
            end else if (done_b) begin
                n_fail++;
                $display("FAIL dut_b spurious done: got done=1, want 0");
            end
        end
    end

    task automatic cyc(input logic stb);
        @(negedge clk);
        sam_clk_en = stb;
        start_a    = 1'b0;
        start_b    = 1'b0;
    endtask

    task automatic strobes(input int cnt, input int per);
        repeat (cnt) begin
            repeat (per - 1) cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    task automatic go(input logic which, input logic [1:0] m, input int a, input int len, input logic stb);
        @(negedge clk);
        mode       = m;
        amp        = W'(a);
        length     = L'(len);
        sam_clk_en = stb;
        start_a    = ~which;
        start_b    = which;
    endtask

    task automatic drain(input string nm);
        repeat (3) cyc(1'b0);
        chk_sig({nm, " outstanding dut_a outputs"}, qa.size(), 0);
        chk_sig({nm, " outstanding dut_b outputs"}, qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_sig("reset x_out a", int'(xa), 0);
        chk_sig("reset busy a", int'(busy_a), 0);
        chk_sig("reset done a", int'(done_a), 0);
        chk_sig("reset x_out b", int'(xb), 0);
        chk_sig("reset busy b", int'(busy_b), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0);

        // Impulse, strobe every 4 cycles
        push(1'b0, 65536, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b0, 0, 1'b0, 1'b1);
        push(1'b0, 0, 1'b1, 1'b0);
        go(1'b0, 2'd0, 65536, 4, 1'b0);
        strobes(5, 4);
        drain("impulse");

        // Step with negative amp; a second start and input changes mid-burst are ignored
        for (int i = 0; i < 3; i++) push(1'b0, -1000, 1'b0, 1'b1);
        push(1'b0, 0, 1'b1, 1'b0);
        go(1'b0, 2'd1, -1000, 3, 1'b0);
        strobes(1, 4);
        go(1'b0, 2'd0, 5, 1, 1'b0);
        strobes(3, 4);
        // Back-to-back zero-length burst: done on its first strobe, x_out stays 0
        push(1'b0, 0, 1'b1, 1'b0);
        go(1'b0, 2'd1, 777, 0, 1'b0);
        strobes(1, 3);
        drain("step/len0");

        // Start coincident with a strobe: first sample on the following strobe
        push(1'b0, 12345, 1'b0, 1'b1);
        push(1'b0, 12345, 1'b0, 1'b1);
        push(1'b0, 0, 1'b1, 1'b0);
        go(1'b0, 2'd1, 12345, 2, 1'b1);
        strobes(3, 2);
        drain("coincident");

        // 4-ASK, continuous strobe
        push_ask(65536, 40);
        go(1'b0, 2'd2, 65536, 40, 1'b0);
        strobes(41, 1);
        drain("ask");

        // Square with saturating amplitude, SPS=2
        push(1'b1, 131071, 1'b0, 1'b1);
        push(1'b1, 131071, 1'b0, 1'b1);
        push(1'b1, -131072, 1'b0, 1'b1);
        push(1'b1, -131072, 1'b0, 1'b1);
        push(1'b1, 131071, 1'b0, 1'b1);
        push(1'b1, 131071, 1'b0, 1'b1);
        push(1'b1, 0, 1'b1, 1'b0);
        go(1'b1, 2'd3, -131072, 6, 1'b0);
        strobes(7, 3);
        drain("square sat");

        // Square with positive amplitude
        push(1'b1, 1000, 1'b0, 1'b1);
        push(1'b1, 1000, 1'b0, 1'b1);
        push(1'b1, -1000, 1'b0, 1'b1);
        push(1'b1, -1000, 1'b0, 1'b1);
        push(1'b1, 1000, 1'b0, 1'b1);
        push(1'b1, 0, 1'b1, 1'b0);
        go(1'b1, 2'd3, 1000, 5, 1'b0);
        strobes(6, 1);
        drain("square pos");

        // Reset mid-burst after samples n=0,1 are out
        push_ask(65536, 10);
        go(1'b0, 2'd2, 65536, 10, 1'b0);
        strobes(2, 2);
        @(negedge clk);
        sam_clk_en = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        chk_sig("mid-burst reset x_out", int'(xa), 0);
        chk_sig("mid-burst reset busy", int'(busy_a), 0);
        chk_sig("mid-burst reset done", int'(done_a), 0);
        @(negedge clk);
        reset = 1'b0;
        qa.delete();
        strobes(3, 2);
        push_ask(65536, 20);
        go(1'b0, 2'd2, 65536, 20, 1'b0);
        strobes(21, 2);
        drain("reset restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
